// File: rtl/johnson_monitor.sv
// johnson_monitor: decodes a Johnson code into phase/one-hot, checks legality and sequencing, tracks lock and counters
module johnson_monitor #(
  parameter int WIDTH = 5,
  parameter int LOCK_LEN = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   jc,
  output logic [3:0]         phase,
  output logic [2*WIDTH-1:0] onehot,
  output logic               valid,
  output logic               locked,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   cycles
);
  localparam int N = 2 * WIDTH;
  localparam int SW = $clog2(LOCK_LEN + 1);
  localparam logic [1:0] UNLOCK = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  logic [1:0]       st;
  logic [3:0]       ref_idx, pc, idx, nxt;
  logic [WIDTH-1:0] canon;
  logic [SW-1:0]    streak, sn;
  logic             legal, step, stall;
  always_comb begin
    pc = '0;
    canon = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + 4'(jc[i]);
    idx = jc[WIDTH-1] ? 4'(N) - pc : pc;
    // regenerate the canonical code for idx; any mismatch means an illegal pattern
    for (int i = 0; i < WIDTH; i++)
      canon[i] = (idx <= 4'(WIDTH)) ? (4'(i) < idx) : (4'(i) >= idx - 4'(WIDTH));
    legal = jc == canon;
    nxt = (ref_idx == 4'(N - 1)) ? 4'd0 : ref_idx + 4'd1;
    step = legal && idx == nxt;
    stall = legal && idx == ref_idx;
    sn = streak + SW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      onehot <= '0;
      valid <= 1'b0;
      locked <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      cycles <= '0;
      st <= UNLOCK;
      streak <= '0;
      ref_idx <= '0;
    end else if (!en) begin
      err <= 1'b0;
    end else begin
      valid <= legal;
      onehot <= legal ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
      if (legal) phase <= idx;
      err <= 1'b0;
      if (st == UNLOCK) begin
        if (legal) begin
          ref_idx <= idx;
          streak <= '0;
          st <= TRACK;
        end
      end else if (step) begin
        ref_idx <= idx;
        if (st == TRACK) begin
          streak <= sn;
          if (sn == SW'(LOCK_LEN)) begin
            st <= LOCKED;
            locked <= 1'b1;
          end
        end else if (ref_idx == 4'(N - 1) && idx == 4'd0) begin
          cycles <= cycles + {{(CNT_W-1){1'b0}}, ~&cycles};
        end
      end else if (!stall) begin
        err <= 1'b1;
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, ~&err_cnt};
        locked <= 1'b0;
        streak <= '0;
        if (legal) ref_idx <= idx;
        st <= legal ? TRACK : UNLOCK;
      end
    end
  end
endmodule

// File: tb/tb_johnson_monitor.sv
// tb_johnson_monitor: directed checks of decode, lock FSM, enable hold, saturation and reset
module tb_johnson_monitor;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [4:0] jc;
  logic [3:0] phase;
  logic [9:0] onehot;
  logic       valid, locked, err;
  logic [7:0] err_cnt, cycles;
  int         checks = 0;
  int         failures = 0;
  logic [4:0] seq [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                           5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  johnson_monitor dut (
    .clk(clk), .rst(rst), .en(en), .jc(jc), .phase(phase), .onehot(onehot),
    .valid(valid), .locked(locked), .err(err), .err_cnt(err_cnt), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic smp(input logic [4:0] c);
    en = 1'b1;
    jc = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    jc = 5'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_onehot"}, 32'(onehot), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
    chk({tag, "_cycles"}, 32'(cycles), 0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    jc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    // acquire lock from reset
    smp(5'b00000);
    chk("t1_phase", 32'(phase), 0);
    chk("t1_onehot", 32'(onehot), 32'b0000000001);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_locked0", 32'(locked), 0);
    smp(5'b00001);
    chk("t1_locked1", 32'(locked), 0);
    smp(5'b00011);
    chk("t1_locked2", 32'(locked), 0);
    smp(5'b00111);
    chk("t1_locked3", 32'(locked), 1);
    chk("t1_phase3", 32'(phase), 3);
    chk("t1_onehot3", 32'(onehot), 32'b0000001000);
    chk("t1_err", 32'(err), 0);
    // two full locked cycles
    for (int i = 4; i < 10; i++) begin
      smp(seq[i]);
      chk("t2_err", 32'(err), 0);
      chk("t2_phase", 32'(phase), 32'(i));
    end
    smp(5'b00000);
    chk("t2_cycles1", 32'(cycles), 1);
    for (int i = 1; i < 10; i++) smp(seq[i]);
    chk("t2_onehot9", 32'(onehot), 32'b1000000000);
    chk("t2_cycles_pre", 32'(cycles), 1);
    smp(5'b00000);
    chk("t2_cycles2", 32'(cycles), 2);
    chk("t2_errcnt", 32'(err_cnt), 0);
    // illegal code while locked
    smp(5'b00101);
    chk("t3_err", 32'(err), 1);
    chk("t3_errcnt", 32'(err_cnt), 1);
    chk("t3_valid", 32'(valid), 0);
    chk("t3_onehot", 32'(onehot), 0);
    chk("t3_phase", 32'(phase), 0);
    chk("t3_locked", 32'(locked), 0);
    idle();
    chk("t3_err_en0", 32'(err), 0);
    chk("t3_valid_en0", 32'(valid), 0);
    smp(5'b00101);
    chk("t3_unlock_noerr", 32'(err), 0);
    chk("t3_unlock_errcnt", 32'(err_cnt), 1);
    smp(5'b00001);
    chk("t3_valid2", 32'(valid), 1);
    chk("t3_relock0", 32'(locked), 0);
    smp(5'b00011);
    smp(5'b00111);
    chk("t3_relock2", 32'(locked), 0);
    smp(5'b01111);
    chk("t3_relock3", 32'(locked), 1);
    chk("t3_phase4", 32'(phase), 4);
    // skip from idx 2 to idx 4
    for (int i = 5; i < 10; i++) smp(seq[i]);
    smp(5'b00000);
    chk("t4_cycles3", 32'(cycles), 3);
    smp(5'b00001);
    smp(5'b00011);
    chk("t4_locked_pre", 32'(locked), 1);
    chk("t4_phase_pre", 32'(phase), 2);
    smp(5'b01111);
    chk("t4_err", 32'(err), 1);
    chk("t4_errcnt", 32'(err_cnt), 2);
    chk("t4_locked", 32'(locked), 0);
    chk("t4_phase", 32'(phase), 4);
    chk("t4_onehot", 32'(onehot), 32'b0000010000);
    smp(5'b11111);
    chk("t4_track_step", 32'(err), 0);
    chk("t4_locked1", 32'(locked), 0);
    smp(5'b11110);
    chk("t4_locked2", 32'(locked), 0);
    smp(5'b11100);
    chk("t4_locked3", 32'(locked), 1);
    // stalls, then enable low with junk on jc
    repeat (3) begin
      smp(5'b11100);
      chk("t5_stall_err", 32'(err), 0);
      chk("t5_stall_locked", 32'(locked), 1);
    end
    repeat (4) begin
      idle();
      chk("t5_hold_phase", 32'(phase), 7);
      chk("t5_hold_onehot", 32'(onehot), 32'b0010000000);
      chk("t5_hold_valid", 32'(valid), 1);
      chk("t5_hold_locked", 32'(locked), 1);
      chk("t5_hold_err", 32'(err), 0);
      chk("t5_hold_errcnt", 32'(err_cnt), 2);
      chk("t5_hold_cycles", 32'(cycles), 3);
    end
    // 260 breaks by bouncing between idx 0 and idx 3
    smp(5'b00000);
    chk("t6_break1", 32'(err_cnt), 3);
    for (int i = 0; i < 259; i++) smp((i % 2 == 0) ? 5'b00111 : 5'b00000);
    chk("t6_errcnt_sat", 32'(err_cnt), 255);
    chk("t6_err_at_sat", 32'(err), 1);
    chk("t6_locked", 32'(locked), 0);
    // relock and saturate the cycle counter
    smp(5'b01111);
    smp(5'b11111);
    smp(5'b11110);
    chk("t6_relock", 32'(locked), 1);
    for (int i = 7; i < 10; i++) smp(seq[i]);
    for (int k = 0; k < 260; k++)
      for (int i = 0; i < 10; i++) smp(seq[i]);
    chk("t6_cycles_sat", 32'(cycles), 255);
    chk("t6_errcnt_hold", 32'(err_cnt), 255);
    chk("t6_err_clean", 32'(err), 0);
    // reset wins over a simultaneous enable
    rst = 1'b1;
    smp(5'b00000);
    chk_zero("midrst");
    rst = 1'b0;
    smp(5'b00011);
    chk("post_rst_phase", 32'(phase), 2);
    chk("post_rst_locked", 32'(locked), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
